// File: rtl/inst_rom_resp.sv
// Purpose: fetch-side instruction memory; registered read of a preloadable word array, NOP+err on bad address.
// Latency: LATENCY cycles request-to-response (1..4), fully pipelined, one response per cycle.
// Backpressure: none; every sampled request is answered in order unless dropped by reset.
module inst_rom_resp #(
    parameter int unsigned AW_WORDS  = 10,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [63:0]         inst_addr,
    input  logic                inst_ena,
    input  logic                ld_en,
    input  logic [AW_WORDS-1:0] ld_addr,
    input  logic [31:0]         ld_data,
    output logic [31:0]         inst,
    output logic [63:0]         inst_pc,
    output logic                inst_valid,
    output logic                inst_err,
    output logic [31:0]         resp_cnt
);

    localparam int unsigned DEPTH    = 1 << AW_WORDS;
    // First byte address past the array; anything at or above it is out of range.
    localparam logic [63:0] END_ADDR = BASE_ADDR + (64'd1 << (AW_WORDS + 2));
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [63:0] pc;
        logic [31:0] dat;
    } resp_t;

    logic [31:0]         mem [DEPTH];
    logic [LATENCY-1:0]  vld_q;
    resp_t               stg_q [LATENCY];
    resp_t               stg0_d;
    logic                req_err;
    logic [AW_WORDS-1:0] req_idx;
    logic [31:0]         resp_cnt_q;
    logic [31:0]         resp_cnt_d;

    // Borrow of the subtraction is discarded; out-of-range indices are masked by req_err.
    assign req_idx = AW_WORDS'((inst_addr - BASE_ADDR) >> 2);
    assign req_err = (inst_addr[1:0] != 2'b00) ||
                     (inst_addr < BASE_ADDR)   ||
                     (inst_addr >= END_ADDR);

    // Preload write port; array is never reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Stage-0 payload: the array read lands in the capture register, so a same-edge
    // preload to the same word is not seen (read-before-write).
    always_comb begin
        stg0_d.err = req_err;
        stg0_d.pc  = inst_addr;
        stg0_d.dat = req_err ? NOP : mem[req_idx];
    end

    // Request pipeline: valid always shifts, payload only moves with a valid beat so
    // the output stage holds its last response through gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= inst_ena;
            if (inst_ena) begin
                stg_q[0] <= stg0_d;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    stg_q[i] <= stg_q[i-1];
                end
            end
        end
    end

    // Count every cycle a response (good or error) is presented; wraps naturally.
    always_comb begin
        resp_cnt_d = resp_cnt_q;
        if (vld_q[LATENCY-1]) begin
            resp_cnt_d = resp_cnt_q + 32'd1;
        end
    end

    // Response counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cnt_q <= '0;
        end else begin
            resp_cnt_q <= resp_cnt_d;
        end
    end

    assign inst       = stg_q[LATENCY-1].dat;
    assign inst_pc    = stg_q[LATENCY-1].pc;
    assign inst_err   = stg_q[LATENCY-1].err;
    assign inst_valid = vld_q[LATENCY-1];
    assign resp_cnt   = resp_cnt_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Purpose: scoreboard bench for inst_rom_resp at LATENCY 2, 1 and 4 driven by shared stimulus.
// Latency: each lane checks arrival edge against its own LATENCY.
// Backpressure: none on the DUT; the bench only throttles via inst_ena gaps.
module tb_inst_rom_resp;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] LIM   = BASE + 64'd4 * DEPTH;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        err;
        int          edge_no;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] inst_addr;
    logic        inst_ena;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic [31:0] inst_w [3];
    logic [63:0] pc_w   [3];
    logic        vld_w  [3];
    logic        err_w  [3];
    logic [31:0] cnt_w  [3];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [31:0] exp_n  = 0;
    logic [31:0] model_mem [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory: NBA so same-edge readers see the old word.
    always @(posedge clk) if (ld_en) model_mem[ld_addr] <= ld_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    endtask

    function automatic exp_t model(input logic [63:0] a, input int e);
        exp_t r;
        r.pc      = a;
        r.edge_no = e;
        r.err     = (a % 4 != 0) || (a < BASE) || (a >= LIM);
        r.inst    = r.err ? 32'h0000_0013 : model_mem[int'((a - BASE) / 4)];
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        exp_t        q[$];
        logic [31:0] last_inst = 0;
        logic [63:0] last_pc   = 0;
        logic        last_err  = 0;

        inst_rom_resp #(.AW_WORDS(10), .BASE_ADDR(BASE), .LATENCY(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .inst_addr (inst_addr),
            .inst_ena  (inst_ena),
            .ld_en     (ld_en),
            .ld_addr   (ld_addr),
            .ld_data   (ld_data),
            .inst      (inst_w[g]),
            .inst_pc   (pc_w[g]),
            .inst_valid(vld_w[g]),
            .inst_err  (err_w[g]),
            .resp_cnt  (cnt_w[g])
        );

        always @(posedge clk) if (rst_n && inst_ena) q.push_back(model(inst_addr, cyc));

        always @(negedge rst_n) q.delete();

        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                chk($sformatf("L%0d rst_vld", L), 64'(vld_w[g]), 64'd0);
                chk($sformatf("L%0d rst_inst", L), 64'(inst_w[g]), 64'd0);
                chk($sformatf("L%0d rst_pc", L), pc_w[g], 64'd0);
                chk($sformatf("L%0d rst_err", L), 64'(err_w[g]), 64'd0);
                chk($sformatf("L%0d rst_cnt", L), 64'(cnt_w[g]), 64'd0);
                last_inst = 0; last_pc = 0; last_err = 0;
            end else if (vld_w[g]) begin
                if (q.size() == 0) begin
                    chk($sformatf("L%0d unexpected_resp", L), pc_w[g], 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("L%0d inst", L), 64'(inst_w[g]), 64'(e.inst));
                    chk($sformatf("L%0d pc", L), pc_w[g], e.pc);
                    chk($sformatf("L%0d err", L), 64'(err_w[g]), 64'(e.err));
                    chk($sformatf("L%0d latency_edge", L), 64'(cyc), 64'(e.edge_no + L));
                end
                last_inst = inst_w[g]; last_pc = pc_w[g]; last_err = err_w[g];
            end else begin
                chk($sformatf("L%0d hold_inst", L), 64'(inst_w[g]), 64'(last_inst));
                chk($sformatf("L%0d hold_pc", L), pc_w[g], last_pc);
                chk($sformatf("L%0d hold_err", L), 64'(err_w[g]), 64'(last_err));
            end
        end
    end

    task automatic drive(input logic e, input logic [63:0] a, input logic l,
                         input logic [9:0] la, input logic [31:0] ld);
        inst_ena = e; inst_addr = a; ld_en = l; ld_addr = la; ld_data = ld;
        if (e && rst_n) exp_n = exp_n + 32'd1;
        @(negedge clk);
    endtask

    task automatic req(input logic [63:0] a);
        drive(1'b1, a, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic chk_cnt(input string nm);
        for (int g = 0; g < 3; g++) chk($sformatf("%s lane%0d", nm, g), 64'(cnt_w[g]), 64'(exp_n));
    endtask

    function automatic logic [63:0] rand_addr();
        int r = $urandom_range(0, 9);
        logic [63:0] w = 64'($urandom_range(0, DEPTH - 1)) * 4;
        if (r == 0) return BASE + w + 64'($urandom_range(1, 3));
        if (r == 1) return BASE - 64'd4 * 64'($urandom_range(1, 16));
        if (r == 2) return LIM + 64'd4 * 64'($urandom_range(0, 16));
        return BASE + w;
    endfunction

    initial begin
        rst_n = 1'b0; inst_ena = 0; inst_addr = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        @(negedge clk);
        // Fill the whole array during reset so every in-range read is defined.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 64'd0, 1'b1, 10'(i), $urandom);
        drive(1'b0, 64'd0, 1'b1, 10'd0, 32'h0010_0093);
        drive(1'b0, 64'd0, 1'b1, 10'd1, 32'h0020_0113);
        drive(1'b0, 64'd0, 1'b1, 10'd2, 32'h0030_0193);
        drive(1'b0, 64'd0, 1'b1, 10'd3, 32'h0040_0213);
        rst_n = 1'b1;
        idle(2);

        // Streaming fetch of the first four words.
        for (int i = 0; i < 4; i++) req(BASE + 64'(i * 4));
        idle(6);
        chk_cnt("stream_cnt");

        // Misaligned, below and above range.
        req(64'h8000_0002); req(64'h7FFF_FFFC); req(64'h8000_1000);
        idle(6);
        chk_cnt("err_cnt");

        // Enable gaps 1,0,0,1.
        req(BASE + 64'h8); idle(2); req(BASE + 64'hC);
        idle(6);

        // Read/write collision on word 5.
        drive(1'b0, 64'd0, 1'b1, 10'd5, 32'hAAAA_AAAA);
        drive(1'b1, BASE + 64'h14, 1'b1, 10'd5, 32'h5555_5555);
        req(BASE + 64'h14);
        idle(6);
        chk_cnt("collide_cnt");

        // Asynchronous reset with two requests in flight.
        req(BASE);
        inst_ena = 1'b1; inst_addr = BASE + 64'h4;
        @(posedge clk);
        #2 rst_n = 1'b0;
        inst_ena = 1'b0;
        exp_n = 0;
        #1;
        for (int g = 0; g < 3; g++) chk($sformatf("async_rst_vld lane%0d", g), 64'(vld_w[g]), 64'd0);
        chk_cnt("async_rst_cnt");
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        req(BASE);
        idle(6);
        chk_cnt("refetch_cnt");

        // Randomized traffic with concurrent preloads.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_addr(), $urandom_range(0, 1) == 1,
                  10'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(6);
        chk_cnt("random_cnt");

        // Counter wrap.
        @(posedge clk);
        #2;
        force lane[0].u_dut.resp_cnt_q = 32'hFFFF_FFFF;
        force lane[1].u_dut.resp_cnt_q = 32'hFFFF_FFFF;
        force lane[2].u_dut.resp_cnt_q = 32'hFFFF_FFFF;
        #1;
        release lane[0].u_dut.resp_cnt_q;
        release lane[1].u_dut.resp_cnt_q;
        release lane[2].u_dut.resp_cnt_q;
        exp_n = 32'hFFFF_FFFF;
        @(negedge clk);
        req(BASE + 64'h4);
        idle(6);
        chk_cnt("wrap_cnt");

        chk("lane0 leftover", 64'(lane[0].q.size()), 64'd0);
        chk("lane1 leftover", 64'(lane[1].q.size()), 64'd0);
        chk("lane2 leftover", 64'(lane[2].q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
